// File: rtl/rot_shift_pkg.sv
// rtl/rot_shift_pkg.sv - shared types for the pipelined rotate/shift unit
// Purpose: op encoding and the width-independent part of the per-stage record.
//   Data, tag and shift amount are width-parameterised and travel beside this record.
// Ports: none (package).
// Optional feature macro: ROT_SHIFT_FLAGS_EN adds carry/zero to the stage record.
package rot_shift_pkg;

   typedef enum logic [2:0] {
      OP_SHR  = 3'b000,
      OP_SHRA = 3'b001,
      OP_SHL  = 3'b010,
      OP_ROR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_PASS = 3'b101
   } op_e;

   typedef struct packed {
      logic valid;
      op_e  op;
`ifdef ROT_SHIFT_FLAGS_EN
      logic carry;
      logic zero;
`endif
   } stage_ctrl_t;

   // Codes 101..111 all behave as pass-through; fold them onto one enum value.
   function automatic op_e decode_op(input logic [2:0] raw);
      return (raw > 3'd4) ? OP_PASS : op_e'(raw);
   endfunction

endpackage

// File: rtl/rot_shift_level.sv
// rtl/rot_shift_level.sv - one registered barrel level of the rotate/shift pipe
// Purpose: applies shift bit LEVEL (right shift or right rotate by 2**LEVEL),
//   registers the result with its tag/op/amount, and provides the stall logic.
//   The last level also undoes the operand bit-reversal used for SHL.
// Ports:
//   clk, clr_n       clock, asynchronous active-low reset
//   flush            synchronous drop of the held operation
//   i_ctrl/i_data/i_shamt/i_tag   record from upstream
//   o_ready          this level can take a record this cycle
//   i_ready          downstream level can take a record this cycle
//   o_ctrl/o_data/o_shamt/o_tag   registered record to downstream
// Optional feature macro: ROT_SHIFT_FLAGS_EN (carry/zero tracking).
module rot_shift_level
   import rot_shift_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int TAG_W   = 4,
   parameter  int LEVEL   = 0,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               flush,
   input  stage_ctrl_t        i_ctrl,
   input  logic [WIDTH-1:0]   i_data,
   input  logic [SHAMT_W-1:0] i_shamt,
   input  logic [TAG_W-1:0]   i_tag,
   output logic               o_ready,
   input  logic               i_ready,
   output stage_ctrl_t        o_ctrl,
   output logic [WIDTH-1:0]   o_data,
   output logic [SHAMT_W-1:0] o_shamt,
   output logic [TAG_W-1:0]   o_tag
);

   localparam int LAT  = SHAMT_W;
   localparam int DIST = 1 << LEVEL;

   stage_ctrl_t        r_ctrl;
   logic [WIDTH-1:0]   r_data;
   logic [SHAMT_W-1:0] r_shamt;
   logic [TAG_W-1:0]   r_tag;

   stage_ctrl_t        w_ctrl;
   logic [WIDTH-1:0]   w_shift;
   logic [WIDTH-1:0]   w_data;
   logic               w_fill;
   logic               w_rot;

   // Empty, or the held record leaves this cycle.
   assign o_ready = ~r_ctrl.valid | i_ready;

   always_comb begin
      w_ctrl  = i_ctrl;
      w_rot   = (i_ctrl.op == OP_ROR) || (i_ctrl.op == OP_ROL);
      // SHRA never sees a reversed operand, so the current MSB is still the original sign.
      w_fill  = (i_ctrl.op == OP_SHRA) & i_data[WIDTH-1];
      w_shift = i_data;
      if (i_shamt[LEVEL]) begin
         if (w_rot) begin
            w_shift = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
         end else begin
            w_shift = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};
         end
      end
      w_data = w_shift;
      if ((LEVEL == LAT - 1) && (i_ctrl.op == OP_SHL)) begin
         for (int b = 0; b < WIDTH; b++) begin
            w_data[b] = w_shift[WIDTH-1-b];
         end
      end
`ifdef ROT_SHIFT_FLAGS_EN
      // Later levels leave the data alone once the amount is exhausted, so the
      // last active level decides the carry. For shifts, bit DIST-1 here is the
      // last bit to fall off overall.
      if (i_shamt[LEVEL]) begin
         if (i_ctrl.op == OP_ROR) begin
            w_ctrl.carry = w_shift[WIDTH-1];
         end else if (i_ctrl.op == OP_ROL) begin
            w_ctrl.carry = w_shift[0];
         end else begin
            w_ctrl.carry = i_data[DIST-1];
         end
      end
      if (LEVEL == LAT - 1) begin
         w_ctrl.zero = (w_data == '0);
      end
`endif
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_ctrl  <= '0;
         r_data  <= '0;
         r_shamt <= '0;
         r_tag   <= '0;
      end else if (flush) begin
         r_ctrl.valid <= 1'b0;
      end else if (o_ready) begin
         r_ctrl  <= w_ctrl;
         r_data  <= w_data;
         r_shamt <= i_shamt;
         r_tag   <= i_tag;
      end
   end

   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;
   assign o_shamt = r_shamt;
   assign o_tag   = r_tag;

endmodule

// File: rtl/rot_shift_pipe.sv
// rtl/rot_shift_pipe.sv - pipelined SHR/SHRA/SHL/ROR/ROL unit, one level per shift bit
// Purpose: log2(WIDTH)-level registered barrel with valid/ready at both ends and a
//   pass-through tag. ROL k runs as ROR (WIDTH-k); SHL runs as a right shift of the
//   bit-reversed operand. Latency is log2(WIDTH) cycles, throughput one per cycle.
// Ports:
//   clk, clr_n                  clock, asynchronous active-low reset
//   flush                       drops every in-flight operation
//   in_valid/in_ready           input handshake
//   in_op/in_data/in_shamt/in_tag  operation, operand, amount, tag
//   out_valid/out_ready         output handshake
//   out_data/out_tag            result and its tag
//   out_carry/out_zero          last bit shifted out, result==0 (flag build only)
// Optional feature macro: ROT_SHIFT_FLAGS_EN.
module rot_shift_pipe
   import rot_shift_pkg::*;
#(
   parameter  int WIDTH   = 32,
   parameter  int TAG_W   = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_op,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag
`ifdef ROT_SHIFT_FLAGS_EN
  ,output logic               out_carry,
   output logic               out_zero
`endif
);

   localparam int                 LAT       = SHAMT_W;
   localparam logic [SHAMT_W-1:0] SHAMT_ONE = 1;

   stage_ctrl_t        w_ent_ctrl;
   logic [WIDTH-1:0]   w_ent_data;
   logic [SHAMT_W-1:0] w_ent_shamt;

   stage_ctrl_t        w_ctrl  [0:LAT];
   logic [WIDTH-1:0]   w_data  [0:LAT];
   logic [SHAMT_W-1:0] w_shamt [0:LAT];
   logic [TAG_W-1:0]   w_tag   [0:LAT];
   logic               w_ready [0:LAT];

   logic [SHAMT_W+$bits(stage_ctrl_t)-1:0] w_unused_last;

   // Normalise every op into a right shift/rotate before the barrel.
   always_comb begin
      w_ent_ctrl       = '0;
      w_ent_ctrl.valid = in_valid & ~flush;
      w_ent_ctrl.op    = decode_op(in_op);
      w_ent_data       = in_data;
      w_ent_shamt      = in_shamt;
      case (w_ent_ctrl.op)
         OP_SHL: begin
            for (int b = 0; b < WIDTH; b++) begin
               w_ent_data[b] = in_data[WIDTH-1-b];
            end
         end
         OP_ROL:  w_ent_shamt = ~in_shamt + SHAMT_ONE;  // (WIDTH-k) mod WIDTH
         OP_PASS: w_ent_shamt = '0;
         default: ;
      endcase
   end

   assign w_ctrl[0]    = w_ent_ctrl;
   assign w_data[0]    = w_ent_data;
   assign w_shamt[0]   = w_ent_shamt;
   assign w_tag[0]     = in_tag;
   assign w_ready[LAT] = out_ready;

   for (genvar g = 0; g < LAT; g++) begin : g_level
      rot_shift_level #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .LEVEL (g)
      ) u_level (
         .clk     (clk),
         .clr_n   (clr_n),
         .flush   (flush),
         .i_ctrl  (w_ctrl[g]),
         .i_data  (w_data[g]),
         .i_shamt (w_shamt[g]),
         .i_tag   (w_tag[g]),
         .o_ready (w_ready[g]),
         .i_ready (w_ready[g+1]),
         .o_ctrl  (w_ctrl[g+1]),
         .o_data  (w_data[g+1]),
         .o_shamt (w_shamt[g+1]),
         .o_tag   (w_tag[g+1])
      );
   end

   assign in_ready  = w_ready[0] & ~flush;
   assign out_valid = w_ctrl[LAT].valid;
   assign out_data  = w_data[LAT];
   assign out_tag   = w_tag[LAT];
`ifdef ROT_SHIFT_FLAGS_EN
   assign out_carry = w_ctrl[LAT].carry;
   assign out_zero  = w_ctrl[LAT].zero;
`endif

   // The amount and op are spent by the time they reach the output.
   assign w_unused_last = {w_shamt[LAT], w_ctrl[LAT]};

endmodule

// File: tb/tb_rot_shift_pipe.sv
// tb/tb_rot_shift_pipe.sv - self-checking bench for rot_shift_pipe
`timescale 1ns/1ps
module tb_rot_shift_pipe;

   localparam int LAT = 5;

   logic        clk       = 1'b0;
   logic        clr_n     = 1'b0;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op     = 3'd0;
   logic [31:0] in_data   = 32'd0;
   logic [4:0]  in_shamt  = 5'd0;
   logic [3:0]  in_tag    = 4'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
`ifdef ROT_SHIFT_FLAGS_EN
   logic        out_carry;
   logic        out_zero;
`endif

   int total = 0;
   int bad   = 0;
   int rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        carry;
      logic        zero;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   rot_shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
`ifdef ROT_SHIFT_FLAGS_EN
     ,.out_carry (out_carry),
      .out_zero  (out_zero)
`endif
   );

   // Reference: what the result must be, straight from the op definitions.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] d,
                                  input int k, input logic [3:0] tag);
      exp_t        e;
      logic [63:0] dd;
      dd      = {d, d};
      e.tag   = tag;
      e.carry = 1'b0;
      case (op)
         3'd0:    e.data = d >> k;
         3'd1:    e.data = 32'($signed(d) >>> k);
         3'd2:    e.data = d << k;
         3'd3:    e.data = 32'(dd >> k);
         3'd4:    e.data = 32'((dd << k) >> 32);
         default: e.data = d;
      endcase
      if (k > 0) begin
         case (op)
            3'd0, 3'd1: e.carry = d[k-1];
            3'd2:       e.carry = d[32-k];
            3'd3:       e.carry = e.data[31];
            3'd4:       e.carry = e.data[0];
            default:    e.carry = 1'b0;
         endcase
      end
      e.zero = (e.data == 32'd0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 1);
   end

   // Output monitor: scoreboard on every transfer, stability while stalled.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data  = 32'd0;
   logic [3:0]  prev_tag   = 4'd0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (!clr_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  out_data, prev_data);
            check("stall_tag",   32'(out_tag), 32'(prev_tag));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: actual data=%h tag=%h required=no result", out_data, out_tag);
            end else begin
               mon_e = exp_q.pop_front();
               check("res_data", out_data, mon_e.data);
               check("res_tag",  32'(out_tag), 32'(mon_e.tag));
`ifdef ROT_SHIFT_FLAGS_EN
               check("res_carry", 32'(out_carry), 32'(mon_e.carry));
               check("res_zero",  32'(out_zero),  32'(mon_e.zero));
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_tag   = out_tag;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid left high.
   task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] k,
                       input logic [3:0] tag, input bit want);
      bit acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_shamt = k;
      in_tag   = tag;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL send_timeout: actual in_ready=0 required=1");
      end else if (want) begin
         exp_q.push_back(model(op, d, int'(k), tag));
      end
   endtask

   task automatic drain();
      int n;
      n        = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: actual pending=%0d required=0", exp_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  out_data, 32'd0);
      check("rst_out_tag",   32'(out_tag), 32'd0);
`ifdef ROT_SHIFT_FLAGS_EN
      check("rst_carry", 32'(out_carry), 32'd0);
      check("rst_zero",  32'(out_zero),  32'd0);
`endif
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      @(negedge clk);
      check("rel_in_ready", 32'(in_ready), 32'd1);

      // Hand-computed pins on the model
      e = model(3'd3, 32'h00000001, 1, 4'd0);
      check("pin_ror", e.data, 32'h80000000);
      check("pin_ror_carry", 32'(e.carry), 32'd1);
      e = model(3'd4, 32'h0000000F, 8, 4'd0);
      check("pin_rol", e.data, 32'h00000F00);
      e = model(3'd1, 32'h80000000, 4, 4'd0);
      check("pin_shra", e.data, 32'hF8000000);
      e = model(3'd2, 32'hC0000000, 1, 4'd0);
      check("pin_shl", e.data, 32'h80000000);
      check("pin_shl_carry", 32'(e.carry), 32'd1);
      e = model(3'd0, 32'h00000001, 1, 4'd0);
      check("pin_shr", e.data, 32'h00000000);
      check("pin_shr_zero", 32'(e.zero), 32'd1);
      check("pin_shr_carry", 32'(e.carry), 32'd1);

      // Latency: ROR 1 by 1 visible exactly LAT cycles after accept
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = 3'd3;
      in_data  = 32'h00000001;
      in_shamt = 5'd1;
      in_tag   = 4'h3;
      @(negedge clk);
      check("lat_accept", 32'(in_ready), 32'd1);
      exp_q.push_back(model(3'd3, 32'h00000001, 1, 4'h3));
      for (int c = 1; c <= LAT; c++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         @(negedge clk);
         if (c < LAT) begin
            check("lat_early", 32'(out_valid), 32'd0);
         end else begin
            check("lat_valid", 32'(out_valid), 32'd1);
            check("lat_data", out_data, 32'h80000000);
            check("lat_tag", 32'(out_tag), 32'h3);
`ifdef ROT_SHIFT_FLAGS_EN
            check("lat_carry", 32'(out_carry), 32'd1);
`endif
         end
      end
      @(posedge clk);
      #1;

      // Directed vectors, including amount 0, pass-through and max amount
      send(3'd4, 32'h0000000F, 5'd8,  4'h1, 1'b1);
      send(3'd1, 32'h80000000, 5'd4,  4'h2, 1'b1);
      send(3'd2, 32'hC0000000, 5'd1,  4'h3, 1'b1);
      send(3'd0, 32'h00000001, 5'd1,  4'h4, 1'b1);
      send(3'd5, 32'h12345678, 5'd7,  4'h5, 1'b1);
      send(3'd7, 32'hCAFEF00D, 5'd31, 4'h6, 1'b1);
      send(3'd3, 32'hA5A5A5A5, 5'd0,  4'h7, 1'b1);
      send(3'd4, 32'h80000001, 5'd0,  4'h8, 1'b1);
      send(3'd1, 32'h80000000, 5'd31, 4'h9, 1'b1);
      send(3'd2, 32'h00000001, 5'd31, 4'hA, 1'b1);
      send(3'd4, 32'h80000000, 5'd31, 4'hB, 1'b1);
      drain();

      // Back-to-back random stream with a random consumer
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) begin
         send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 4'(i), 1'b1);
      end
      drain();
      rdy_mode = 1;
      repeat (2) @(posedge clk);
      #1;

      // Flush with three ops in flight and a fourth offered
      for (int i = 0; i < 3; i++) begin
         send(3'd0, 32'hFFFF0000 + 32'(i), 5'd4, 4'hC, 1'b0);
      end
      in_valid = 1'b1;
      in_op    = 3'd3;
      in_data  = 32'h0000DEAD;
      in_shamt = 5'd2;
      in_tag   = 4'hD;
      flush    = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("flush_quiet", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(3'd4, 32'h80000001, 5'd1, 4'hE, 1'b1);
      drain();

      // Async reset with the pipeline full and stalled
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < LAT; i++) begin
         send(3'd0, 32'hF0F0F0F0, 5'd0, 4'hF, 1'b0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      #2;
      clr_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data", out_data, 32'd0);
      check("arst_out_tag", 32'(out_tag), 32'd0);
      @(posedge clk);
      #1;
      rdy_mode = 1;
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      @(negedge clk);
      check("arst_rel_in_ready", 32'(in_ready), 32'd1);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("arst_quiet", 32'(out_valid), 32'd0);
      end

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
